mm_row_seq: RTL

Sequencer and accumulator that sits directly upstream of matrix_ops and closes its accumulator loop. It accepts one 8-word row of A, then streams 8 rows of B. For each B row k it drives matrix_ops with mm_en=1, mm_op=k+1 and cin set to the accumulator, and registers co back into the accumulator. After 8 beats it presents the finished 256-bit C row on a valid/ready output port. All arithmetic is performed by matrix_ops; this block only sequences, holds state and handshakes.

---
 rtl/mm_row_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/mm_row_seq.sv
// Row sequencer for matrix_ops: latches one A row, streams NWORDS B rows
// through the external accumulator loop, then hands off the finished C row.
module mm_row_seq #(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned WORD_W = 32,
  localparam int unsigned RW = NWORDS * WORD_W,
  localparam int unsigned KW = $clog2(NWORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [RW-1:0] a_row,
  input  logic [RW-1:0] acc_init,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [RW-1:0] b_row,
  output logic          mm_en,
  output logic [5:0]    mm_op,
  output logic [RW-1:0] mm_a,
  output logic [RW-1:0] mm_b,
  output logic [RW-1:0] mm_cin,
  input  logic [RW-1:0] mm_co,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [RW-1:0] c_row,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_a;
  logic [RW-1:0] r_acc;
  logic [KW-1:0] r_k;
  logic          w_last;
  logic [5:0]    w_op;

  assign w_last = (r_k == K_LAST);
  assign w_op   = 6'(r_k) + 6'd1;

  assign mm_a   = r_a;
  assign mm_b   = b_row;
  assign mm_cin = r_acc;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_acc   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (a_valid) begin
            r_a   <= a_row;
            r_acc <= acc_init;
            r_k   <= '0;
          end
        end
        S_ACC: begin
          if (b_valid) begin
            r_acc <= mm_co;
            r_k   <= w_last ? '0 : r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // c_ready and b_valid only steer the next state, never the ready outputs
  always_comb begin
    w_next  = r_state;
    a_ready = 1'b0;
    b_ready = 1'b0;
    mm_en   = 1'b0;
    mm_op   = '0;
    c_valid = 1'b0;
    c_row   = '0;
    unique case (r_state)
      S_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) w_next = S_ACC;
      end
      S_ACC: begin
        b_ready = 1'b1;
        mm_en   = b_valid;
        mm_op   = b_valid ? w_op : 6'd0;
        if (b_valid && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        c_valid = 1'b1;
        c_row   = r_acc;
        if (c_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
